// File: rtl/router_port_rx.sv
// Serial-to-byte receiver for a router output port: rebuilds LSB-first bytes and queues them in a FIFO.
// Optional ROUTER_RX_ERR_CHK_EN adds err_frame/err_cnt framing-error reporting.
module router_port_rx #(
  parameter int unsigned BYTE_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              din,
  input  logic              valid_n,
  input  logic              frame_n,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_last,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic              pkt_done,
  output logic              overflow
`ifdef ROUTER_RX_ERR_CHK_EN
  ,
  output logic              err_frame,
  output logic [7:0]        err_cnt
`endif
);

  localparam int unsigned CNT_W = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BYTE_W - 1);

  typedef enum logic [1:0] {SYNC, IDLE, RECV} state_t;

  state_t            state, next_state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [BYTE_W-1:0] shreg, word;
  logic              capture, end_evt, byte_done;

  logic [BYTE_W:0]   mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr, rd_ptr;
  logic              fifo_empty, fifo_full, push, pop;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= SYNC;
    else          state <= next_state;
  end

  // end_evt covers both a final captured bit and an abort (frame_n high with no valid bit)
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    end_evt    = 1'b0;
    case (state)
      SYNC: if (frame_n) next_state = IDLE;
      IDLE: if (!frame_n) begin
        next_state = RECV;
        capture    = !valid_n;
      end
      RECV: begin
        if (!valid_n) capture = 1'b1;
        if (frame_n) begin
          end_evt    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = SYNC;
    endcase
  end

  assign byte_done = capture && (bit_cnt == LAST_BIT);

  always_comb begin
    word          = shreg;
    word[bit_cnt] = din;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      pkt_done <= 1'b0;
    end else begin
      pkt_done <= end_evt;
      if (capture) shreg[bit_cnt] <= din;
      if (byte_done || end_evt) bit_cnt <= '0;
      else if (capture)         bit_cnt <= bit_cnt + 1'b1;
    end
  end

  // Extra pointer MSB distinguishes full from empty when the index bits match
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop        = !fifo_empty && byte_ready;
  assign push       = byte_done && (!fifo_full || pop);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {frame_n, word};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (byte_done && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  assign byte_valid = !fifo_empty;
  assign {byte_last, byte_data} = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

`ifdef ROUTER_RX_ERR_CHK_EN
  logic err_evt;

  // Truncated end or abort (end without a completed byte), or a stray bit while idle
  assign err_evt = (end_evt && !byte_done) ||
                   ((state == IDLE) && frame_n && !valid_n);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_frame <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_frame <= err_evt;
      if (err_evt && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule
